core_avalon_bridge: RTL and testbench



---
 rtl/core_avalon_bridge_pkg.sv | 25 ++
 rtl/core_avalon_bridge.sv | 166 ++++++++++++++++
 tb/tb_core_avalon_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_avalon_bridge_pkg.sv
// Shared micro-architecture types for the core memory port and its
// Avalon-MM bridge.
//   ptr_t  : word address of the core memory port
//   word_t : data word
//   be_t   : byte enables, one per byte of word_t
// POISON_DEFAULT is the read data handed back to the core when an access
// is abandoned by the timeout.
package core_avalon_bridge_pkg;

    localparam int unsigned PTR_W  = 30;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BE_W-1:0]   be_t;

    localparam word_t POISON_DEFAULT = 32'hDEAD_BEEF;

    // Word address to byte address on the interconnect.
    function automatic logic [31:0] byte_addr(input ptr_t p);
        return {p, 2'b00};
    endfunction

endpackage

// File: rtl/core_avalon_bridge.sv
// Bridge from the core's word-addressed memory port to an Avalon-MM master.
// One transaction in flight at a time; arbitrary wait states and read
// latency; every access bounded by a timeout that completes it with POISON
// read data and sets a sticky error flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_addr/start/write  core request (start is a one-cycle strobe)
//   bus_data_wr/be        write data and byte enables
//   bus_ready             one-cycle completion pulse
//   bus_data_rd           read data, held until the next read completes
//   avl_*                 Avalon-MM master command / response signals
//   err_clear, bus_err    sticky timeout flag and its clear
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no access; accepts bus_start (also in the bus_ready cycle)
// ISSUE     | command strobe high, waiting for waitrequest to drop
// WAIT_DATA | read accepted, waiting for readdatavalid
module core_avalon_bridge
    import core_avalon_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter word_t       POISON  = POISON_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ptr_t        bus_addr,
    input  logic        bus_start,
    input  logic        bus_write,
    input  word_t       bus_data_wr,
    input  be_t         bus_data_be,
    output logic        bus_ready,
    output word_t       bus_data_rd,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output word_t       avl_writedata,
    output be_t         avl_byteenable,
    input  logic        avl_waitrequest,
    input  word_t       avl_readdata,
    input  logic        avl_readdatavalid,
    input  logic        err_clear,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    // A zero TIMEOUT still needs a one-bit counter to keep widths legal.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    state_t        state, state_nxt;
    ptr_t          addr_q;
    logic          wr_q;
    word_t         wdata_q;
    be_t           be_q;
    logic [CW-1:0] cnt, cnt_inc;
    logic          stale;

    logic done, take_data, timed_out, tmo_hit, stale_drop;
    logic issue_nxt, wr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        done       = 1'b0;
        take_data  = 1'b0;
        timed_out  = 1'b0;
        cnt_inc    = cnt + 1'b1;
        // The count leaving this cycle reaching TIMEOUT means TIMEOUT cycles
        // have now been spent in ISSUE/WAIT_DATA.
        tmo_hit    = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);
        // A stale response is swallowed whatever state we are in.
        stale_drop = stale && avl_readdatavalid;
        case (state)
            IDLE: begin
                if (bus_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Acceptance wins over a timeout landing in the same cycle.
                if (!avl_waitrequest) begin
                    if (wr_q) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end else if (tmo_hit) begin
                    timed_out = 1'b1;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                if (avl_readdatavalid && !stale) begin
                    take_data = 1'b1;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    timed_out = 1'b1;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        issue_nxt = (state_nxt == ISSUE);
        wr_nxt    = (state == IDLE) ? bus_write : wr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt         <= '0;
            avl_read    <= 1'b0;
            avl_write   <= 1'b0;
            bus_ready   <= 1'b0;
            bus_data_rd <= '0;
            bus_err     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            // Holding registers only load in IDLE, so a stray bus_start
            // during an access cannot disturb the command in flight.
            if (state == IDLE) begin
                cnt <= '0;
                if (bus_start) begin
                    addr_q  <= bus_addr;
                    wr_q    <= bus_write;
                    wdata_q <= bus_data_wr;
                    be_q    <= bus_data_be;
                end
            end else begin
                cnt <= cnt_inc;
            end

            avl_read  <= issue_nxt && !wr_nxt;
            avl_write <= issue_nxt && wr_nxt;
            bus_ready <= done;

            if (take_data)
                bus_data_rd <= avl_readdata;
            else if (timed_out && !wr_q)
                bus_data_rd <= POISON;

            if (timed_out)      bus_err <= 1'b1;
            else if (err_clear) bus_err <= 1'b0;

            // The abandoned read's data will still arrive; mark it to drop.
            if (timed_out && (state == WAIT_DATA)) stale <= 1'b1;
            else if (stale_drop)                   stale <= 1'b0;
        end
    end

    assign avl_address    = byte_addr(addr_q);
    assign avl_writedata  = wdata_q;
    assign avl_byteenable = be_q;

endmodule

// File: tb/tb_core_avalon_bridge.sv
// Self-checking bench for core_avalon_bridge (TIMEOUT = 8).
// Expected completions are queued when an access is started and compared
// by a monitor whenever bus_ready pulses; scenario tasks check command
// signals and cycle timing inline.
module tb_core_avalon_bridge;
    import core_avalon_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ptr_t        bus_addr = '0;
    logic        bus_start = 1'b0;
    logic        bus_write = 1'b0;
    word_t       bus_data_wr = '0;
    be_t         bus_data_be = '0;
    logic        bus_ready;
    word_t       bus_data_rd;
    logic [31:0] avl_address;
    logic        avl_read, avl_write;
    word_t       avl_writedata;
    be_t         avl_byteenable;
    logic        avl_waitrequest = 1'b0;
    word_t       avl_readdata = '0;
    logic        avl_readdatavalid = 1'b0;
    logic        err_clear = 1'b0;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic  wr;
        word_t data;
        logic  err;
    } exp_t;
    exp_t sb[$];

    core_avalon_bridge #(.TIMEOUT(8), .POISON(32'hDEAD_BEEF)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_addr         (bus_addr),
        .bus_start        (bus_start),
        .bus_write        (bus_write),
        .bus_data_wr      (bus_data_wr),
        .bus_data_be      (bus_data_be),
        .bus_ready        (bus_ready),
        .bus_data_rd      (bus_data_rd),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .err_clear        (err_clear),
        .bus_err          (bus_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every completion must match the oldest access.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ready: bus_ready=1 with no access outstanding");
            end else begin
                e = sb.pop_front();
                if (!e.wr) begin
                    checks++;
                    if (bus_data_rd !== e.data) begin
                        errors++;
                        $display("FAIL sb_read_data: got %h want %h", bus_data_rd, e.data);
                    end
                end
                checks++;
                if (bus_err !== e.err) begin
                    errors++;
                    $display("FAIL sb_bus_err: got %b want %b", bus_err, e.err);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_access(input logic wr, input ptr_t a, input word_t d,
                                input be_t be, input word_t exp_rd, input logic exp_err);
        exp_t e;
        bus_start   = 1'b1;
        bus_write   = wr;
        bus_addr    = a;
        bus_data_wr = d;
        bus_data_be = be;
        e.wr   = wr;
        e.data = exp_rd;
        e.err  = exp_err;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if ({avl_read, avl_write, bus_ready, bus_err, avl_address, avl_writedata,
             avl_byteenable, bus_data_rd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b rdy=%b err=%b addr=%h wd=%h be=%h rdata=%h (want all 0)",
                     avl_read, avl_write, bus_ready, bus_err, avl_address, avl_writedata,
                     avl_byteenable, bus_data_rd);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_write;
        start_access(1'b1, 30'h0000_0100, 32'h1234_5678, 4'b0011, '0, 1'b0);   // cycle 0
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        checks++;
        if ({avl_write, avl_read, avl_address, avl_byteenable, avl_writedata, bus_ready} !==
            {1'b1, 1'b0, 32'h0000_0400, 4'b0011, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL write_cmd: wr=%b rd=%b addr=%h be=%b wd=%h rdy=%b want wr=1 rd=0 addr=00000400 be=0011 wd=12345678 rdy=0",
                     avl_write, avl_read, avl_address, avl_byteenable, avl_writedata, bus_ready);
        end
        tick;                                                                   // cycle 2
        checks++;
        if ({bus_ready, avl_write} !== 2'b10) begin
            errors++;
            $display("FAIL write_ready_c2: rdy=%b wr=%b want rdy=1 wr=0", bus_ready, avl_write);
        end
        tick;
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_one_cycle: got %b want 0", bus_ready);
        end
    endtask

    task automatic test_read_wait;
        start_access(1'b0, 30'h0000_0033, '0, 4'hF, 32'hCAFE_F00D, 1'b0);      // cycle 0
        avl_waitrequest = 1'b1;
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({avl_read, avl_write, avl_address, avl_byteenable} !== {1'b1, 1'b0, 32'h0000_00CC, 4'hF}) begin
                errors++;
                $display("FAIL read_stall_stable c%0d: rd=%b wr=%b addr=%h be=%h want rd=1 wr=0 addr=000000cc be=f",
                         c, avl_read, avl_write, avl_address, avl_byteenable);
            end
            tick;
        end
        avl_waitrequest = 1'b0;                                                 // cycle 4
        checks++;
        if (avl_read !== 1'b1) begin
            errors++;
            $display("FAIL read_accept_c4: avl_read=%b want 1", avl_read);
        end
        tick;                                                                   // cycle 5
        checks++;
        if ({avl_read, bus_ready} !== 2'b00) begin
            errors++;
            $display("FAIL read_wait_c5: rd=%b rdy=%b want 0 0", avl_read, bus_ready);
        end
        tick;                                                                   // cycle 6
        avl_readdata      = 32'hCAFE_F00D;
        avl_readdatavalid = 1'b1;
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_early_ready_c6: got %b want 0", bus_ready);
        end
        tick;                                                                   // cycle 7
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        checks++;
        if ({bus_ready, bus_data_rd} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL read_ready_c7: rdy=%b data=%h want rdy=1 data=cafef00d", bus_ready, bus_data_rd);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        start_access(1'b1, 30'h0000_0010, 32'h1111_0000, 4'hF, '0, 1'b0);      // cycle 0
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        tick;                                                                   // cycle 2
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready: got %b want 1", bus_ready);
        end
        start_access(1'b1, 30'h0000_0011, 32'h2222_0000, 4'b1100, '0, 1'b0);
        tick;                                                                   // cycle 3
        bus_start = 1'b0;
        checks++;
        if ({avl_write, avl_address, avl_writedata, avl_byteenable} !==
            {1'b1, 32'h0000_0044, 32'h2222_0000, 4'b1100}) begin
            errors++;
            $display("FAIL b2b_second_cmd: wr=%b addr=%h wd=%h be=%b want wr=1 addr=00000044 wd=22220000 be=1100",
                     avl_write, avl_address, avl_writedata, avl_byteenable);
        end
        tick;                                                                   // cycle 4
        checks++;
        if ({bus_ready, bus_data_rd} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL b2b_second_ready_hold: rdy=%b data=%h want rdy=1 data=cafef00d", bus_ready, bus_data_rd);
        end
        tick;
    endtask

    task automatic test_ignore_start;
        start_access(1'b1, 30'h0000_0009, 32'hAAAA_0001, 4'hF, '0, 1'b0);      // cycle 0
        avl_waitrequest = 1'b1;
        tick;                                                                   // cycle 1
        bus_start   = 1'b1;
        bus_write   = 1'b0;
        bus_addr    = 30'h0000_0055;
        bus_data_wr = 32'h5555_5555;
        bus_data_be = 4'h1;
        tick;                                                                   // cycle 2
        bus_start = 1'b0;
        checks++;
        if ({avl_write, avl_read, avl_address, avl_writedata, avl_byteenable} !==
            {1'b1, 1'b0, 32'h0000_0024, 32'hAAAA_0001, 4'hF}) begin
            errors++;
            $display("FAIL ignore_start_cmd: wr=%b rd=%b addr=%h wd=%h be=%h want wr=1 rd=0 addr=00000024 wd=aaaa0001 be=f",
                     avl_write, avl_read, avl_address, avl_writedata, avl_byteenable);
        end
        avl_waitrequest = 1'b0;
        tick;                                                                   // cycle 3
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_ready: got %b want 1", bus_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if ({avl_read, avl_write, bus_ready} !== 3'b000) begin
                errors++;
                $display("FAIL ignore_start_idle: rd=%b wr=%b rdy=%b want 0 0 0", avl_read, avl_write, bus_ready);
            end
        end
    endtask

    task automatic test_timeout_stale;
        start_access(1'b0, 30'h0000_0077, '0, 4'hF, 32'hDEAD_BEEF, 1'b1);      // cycle 0
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({bus_ready, bus_err} !== 2'b00) begin
                errors++;
                $display("FAIL timeout_early c%0d: rdy=%b err=%b want 0 0", c, bus_ready, bus_err);
            end
            tick;
        end
        checks++;                                                               // cycle 9
        if ({bus_ready, bus_err, avl_read, bus_data_rd} !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL timeout_c9: rdy=%b err=%b rd=%b data=%h want 1 1 0 deadbeef",
                     bus_ready, bus_err, avl_read, bus_data_rd);
        end
        start_access(1'b0, 30'h0000_0078, '0, 4'hF, 32'h2222_3333, 1'b1);
        tick;                                                                   // cycle 10
        bus_start = 1'b0;
        checks++;
        if (avl_read !== 1'b1) begin
            errors++;
            $display("FAIL stale_read_issue: avl_read=%b want 1", avl_read);
        end
        tick;                                                                   // cycle 11
        avl_readdata      = 32'h1111_1111;
        avl_readdatavalid = 1'b1;
        tick;                                                                   // cycle 12
        avl_readdata = 32'h2222_3333;
        checks++;
        if ({bus_ready, bus_data_rd} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL stale_discard: rdy=%b data=%h want rdy=0 data=deadbeef", bus_ready, bus_data_rd);
        end
        tick;                                                                   // cycle 13
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        checks++;
        if ({bus_ready, bus_data_rd} !== {1'b1, 32'h2222_3333}) begin
            errors++;
            $display("FAIL stale_own_data: rdy=%b data=%h want rdy=1 data=22223333", bus_ready, bus_data_rd);
        end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: bus_err=%b want 0", bus_err);
        end
        tick;
    endtask

    task automatic test_reset_mid_op;
        start_access(1'b0, 30'h0000_0005, '0, 4'hF, '0, 1'b0);                 // cycle 0
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        tick;                                                                   // cycle 2, WAIT_DATA
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({avl_read, avl_write, bus_ready, bus_err, avl_address, avl_writedata,
             avl_byteenable, bus_data_rd} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: rd=%b wr=%b rdy=%b err=%b addr=%h wd=%h be=%h rdata=%h (want all 0)",
                     avl_read, avl_write, bus_ready, bus_err, avl_address, avl_writedata,
                     avl_byteenable, bus_data_rd);
        end
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if ({bus_ready, avl_read} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_ready: rdy=%b rd=%b want 0 0", bus_ready, avl_read);
            end
        end
        start_access(1'b0, 30'h0000_0007, '0, 4'hF, 32'h0BAD_CAFE, 1'b0);      // cycle 0
        tick;                                                                   // cycle 1
        bus_start = 1'b0;
        tick;                                                                   // cycle 2
        avl_readdata      = 32'h0BAD_CAFE;
        avl_readdatavalid = 1'b1;
        tick;                                                                   // cycle 3
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        checks++;
        if ({bus_ready, bus_data_rd} !== {1'b1, 32'h0BAD_CAFE}) begin
            errors++;
            $display("FAIL post_reset_read: rdy=%b data=%h want rdy=1 data=0badcafe", bus_ready, bus_data_rd);
        end
        tick;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_ignore_start();
        test_timeout_stale();
        test_reset_mid_op();
        tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d completions outstanding, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
